// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - request/status bundle between game logic and the PS/2 host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_active;
  logic       done;
  logic       err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_active,
    input  done,
    input  err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_active,
    output done,
    output err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter; define PS2_TX_RETRY_EN for one automatic retry
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire          PS2_CLK,
  inout  wire          PS2_DATA,
  ps2_host_tx_if.slave bus
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SEND, S_ACK, S_WAIT_IDLE, S_FAIL, S_RETRY
  } state_t;

  state_t        state, state_nxt, fail_state;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          ps2_clk_s, ps2_data_s, fall;
  logic [8:0]    frame;
  logic [3:0]    edge_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic          data_low;
  logic          inh_last, to_hit, accept;

  assign ps2_clk_s  = clk_sync[1];
  assign ps2_data_s = data_sync[1];
  assign fall       = clk_prev & ~ps2_clk_s;
  assign inh_last   = (state == S_INHIBIT) && (inh_cnt == INH_LAST);
  assign to_hit     = (to_cnt == TO_LAST);

  assign bus.tx_ready  = (state == S_IDLE);
  assign bus.tx_active = (state != S_IDLE);
  assign accept        = bus.tx_valid && (state == S_IDLE);
  assign bus.done      = (state == S_WAIT_IDLE) && ps2_clk_s && ps2_data_s;
  assign bus.err       = (state == S_FAIL);

  // Open-drain drives: clock held low only while inhibiting, data low for start bit and zero bits
  assign PS2_CLK  = (state == S_INHIBIT) ? 1'b0 : 1'bz;
  assign PS2_DATA = (inh_last || ((state == S_SEND) && data_low)) ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus previous clock sample; idle lines read high so reset to 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
      clk_prev  <= ps2_clk_s;
    end
  end

`ifdef PS2_TX_RETRY_EN
  logic retried;

  // Remember that the single retry has been spent for the current byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    retried <= 1'b0;
    else if (state == S_IDLE)    retried <= 1'b0;
    else if (state == S_RETRY)   retried <= 1'b1;
  end

  // First failure restarts the frame, second one reports
  always_comb begin
    fail_state = S_FAIL;
    if (!retried) fail_state = S_RETRY;
  end
`else
  // Any failure reports immediately
  always_comb begin
    fail_state = S_FAIL;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a device edge wins over a timeout landing in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (accept) state_nxt = S_INHIBIT;
      S_INHIBIT:   if (inh_last) state_nxt = S_SEND;
      S_SEND: begin
        if (fall && (edge_cnt == 4'd9)) state_nxt = S_ACK;
        else if (!fall && to_hit)       state_nxt = fail_state;
      end
      S_ACK: begin
        if (fall)        state_nxt = ps2_data_s ? fail_state : S_WAIT_IDLE;
        else if (to_hit) state_nxt = fail_state;
      end
      S_WAIT_IDLE: begin
        if (ps2_clk_s && ps2_data_s) state_nxt = S_IDLE;
        else if (!fall && to_hit)    state_nxt = fail_state;
      end
      S_FAIL:      state_nxt = S_IDLE;
      S_RETRY:     state_nxt = S_INHIBIT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Frame latch, inhibit/edge/timeout counters and the registered data-bit drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame    <= '0;
      edge_cnt <= '0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      data_low <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          edge_cnt <= '0;
          inh_cnt  <= '0;
          to_cnt   <= '0;
          data_low <= 1'b0;
          if (accept) frame <= {~^bus.tx_data, bus.tx_data};
        end
        S_INHIBIT: begin
          inh_cnt <= inh_cnt + IW'(1);
          if (inh_last) begin
            inh_cnt  <= '0;
            to_cnt   <= '0;
            edge_cnt <= '0;
            data_low <= 1'b1;
          end
        end
        S_SEND: begin
          if (fall) begin
            to_cnt   <= '0;
            edge_cnt <= edge_cnt + 4'd1;
            if (edge_cnt <= 4'd8) data_low <= ~frame[edge_cnt];
            else                  data_low <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_ACK, S_WAIT_IDLE: begin
          data_low <= 1'b0;
          if (fall) to_cnt <= '0;
          else      to_cnt <= to_cnt + TW'(1);
        end
        default: begin
          edge_cnt <= '0;
          inh_cnt  <= '0;
          to_cnt   <= '0;
          data_low <= 1'b0;
        end
      endcase
    end
  end
endmodule
